// File: rtl/nvram_upload_responder_pkg.sv
// Shared types and helpers for the NVRAM upload (save) responder and its download counterpart.
package nvram_upload_responder_pkg;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;

  localparam logic [7:0]  NVRAM_INDEX = 8'h02;
  localparam logic [15:0] FILL_WORD   = 16'hFFFF;

  // HPS sees bytes in the opposite order from the core's 16-bit memory words
  function automatic logic [15:0] byte_swap(input logic [15:0] w);
    return {w[7:0], w[15:8]};
  endfunction

endpackage

// File: rtl/nvram_upload_responder_if.sv
// ioctl upload side plus memory read port; master = HPS/memory environment, slave = responder.
interface nvram_upload_responder_if #(parameter int ADDR_WIDTH = 16);
  logic                  io_ioctl_upload;
  logic                  io_ioctl_rd;
  logic [7:0]            io_ioctl_index;
  logic [26:0]           io_ioctl_addr;
  logic [15:0]           io_ioctl_din;
  logic                  io_ioctl_waitReq;
  logic                  io_mem_rd;
  logic [ADDR_WIDTH-2:0] io_mem_addr;
  logic                  io_mem_waitReq;
  logic [15:0]           io_mem_dout;
  logic                  io_mem_valid;

  modport master (
    output io_ioctl_upload, io_ioctl_rd, io_ioctl_index, io_ioctl_addr,
    output io_mem_waitReq, io_mem_dout, io_mem_valid,
    input  io_ioctl_din, io_ioctl_waitReq, io_mem_rd, io_mem_addr
  );

  modport slave (
    input  io_ioctl_upload, io_ioctl_rd, io_ioctl_index, io_ioctl_addr,
    input  io_mem_waitReq, io_mem_dout, io_mem_valid,
    output io_ioctl_din, io_ioctl_waitReq, io_mem_rd, io_mem_addr
  );
endinterface

// File: rtl/nvram_upload_responder_edge_detect.sv
// Upload rise/fall detection; done pulses once the responder is (or is just returning to) IDLE.
module upload_edge_detect (
  input  logic clock,
  input  logic reset,
  input  logic i_upload,
  input  logic i_idle,
  input  logic i_exit,
  output logic o_rise,
  output logic o_done
);
  logic r_prev, r_pend;
  logic w_fall, w_home;

  assign w_fall = r_prev & ~i_upload;
  assign o_rise = i_upload & ~r_prev;
  assign w_home = i_idle | i_exit;

  // a fall seen mid-read is remembered until the FSM gets back to IDLE
  always_ff @(posedge clock) begin
    if (reset) begin
      r_prev <= 1'b0;
      r_pend <= 1'b0;
      o_done <= 1'b0;
    end else begin
      r_prev <= i_upload;
      r_pend <= (r_pend | w_fall) & ~w_home;
      o_done <= (r_pend | w_fall) & w_home;
    end
  end
endmodule

// File: rtl/nvram_upload_responder.sv
// Answers HPS upload reads from NVRAM backing memory, with out-of-window fill and read timeout.
module nvram_upload_responder
  import nvram_upload_responder_pkg::*;
#(
  parameter logic [7:0] INDEX      = NVRAM_INDEX,
  parameter int         ADDR_WIDTH = 16,
  parameter int         SIZE_BYTES = 128,
  parameter int         TIMEOUT    = 255
) (
  input  logic                     clock,
  input  logic                     reset,
  nvram_upload_responder_if.slave  bus,
  output logic                     io_error,
  output logic                     io_done
);
  localparam int CW = $clog2(TIMEOUT + 1);

  state_t                r_state;
  logic [15:0]           r_din;
  logic                  r_waitreq, r_mem_rd, r_error;
  logic [ADDR_WIDTH-2:0] r_addr;
  logic [CW-1:0]         r_cnt;
  logic                  w_acc, w_cnt_end, w_exit, w_rise;

  assign w_acc     = bus.io_ioctl_upload && bus.io_ioctl_rd && (bus.io_ioctl_index == INDEX);
  assign w_cnt_end = (r_cnt == CW'(TIMEOUT - 1));
  assign w_exit    = ((r_state == REQ) && !bus.io_ioctl_upload) ||
                     ((r_state == DRAIN) && (bus.io_mem_valid || w_cnt_end));

  assign bus.io_ioctl_din     = r_din;
  assign bus.io_ioctl_waitReq = r_waitreq;
  assign bus.io_mem_rd        = r_mem_rd;
  assign bus.io_mem_addr      = r_addr;
  assign io_error             = r_error;

  upload_edge_detect u_edge (
    .clock    (clock),
    .reset    (reset),
    .i_upload (bus.io_ioctl_upload),
    .i_idle   (r_state == IDLE),
    .i_exit   (w_exit),
    .o_rise   (w_rise),
    .o_done   (io_done)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= IDLE;
      r_din     <= '0;
      r_waitreq <= 1'b0;
      r_mem_rd  <= 1'b0;
      r_addr    <= '0;
      r_error   <= 1'b0;
      r_cnt     <= '0;
    end else begin
      if (w_rise) r_error <= 1'b0;
      if (w_acc && (r_waitreq || r_state == DRAIN)) r_error <= 1'b1;
      unique case (r_state)
        // waitReq may still be high for one cycle after data lands
        IDLE: begin
          r_waitreq <= 1'b0;
          if (w_acc && !r_waitreq) begin
            if (bus.io_ioctl_addr < 27'(SIZE_BYTES)) begin
              r_addr    <= bus.io_ioctl_addr[ADDR_WIDTH-1:1];
              r_waitreq <= 1'b1;
              r_mem_rd  <= 1'b1;
              r_state   <= REQ;
            end else begin
              r_din <= FILL_WORD;
            end
          end
        end
        REQ: begin
          if (!bus.io_ioctl_upload) begin
            r_mem_rd  <= 1'b0;
            r_waitreq <= 1'b0;
            r_state   <= IDLE;
          end else if (!bus.io_mem_waitReq) begin
            r_mem_rd <= 1'b0;
            r_cnt    <= '0;
            r_state  <= WAIT;
          end
        end
        WAIT: begin
          if (bus.io_mem_valid) begin
            r_din   <= byte_swap(bus.io_mem_dout);
            r_state <= IDLE;
          end else if (!bus.io_ioctl_upload) begin
            r_waitreq <= 1'b0;
            r_cnt     <= '0;
            r_state   <= DRAIN;
          end else if (w_cnt_end) begin
            r_din     <= FILL_WORD;
            r_error   <= 1'b1;
            r_waitreq <= 1'b0;
            r_cnt     <= '0;
            r_state   <= DRAIN;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        DRAIN: begin
          if (bus.io_mem_valid || w_cnt_end) r_state <= IDLE;
          else                               r_cnt   <= r_cnt + CW'(1);
        end
      endcase
    end
  end
endmodule

// File: tb/tb_nvram_upload_responder.sv
// Directed bench for nvram_upload_responder with an inline memory model and din scoreboard.
module tb_nvram_upload_responder;
  logic clock = 1'b0;
  logic reset;
  logic io_error, io_done;

  always #5 clock = ~clock;

  nvram_upload_responder_if #(.ADDR_WIDTH(16)) bus ();

  nvram_upload_responder #(
    .INDEX(8'h02), .ADDR_WIDTH(16), .SIZE_BYTES(128), .TIMEOUT(8)
  ) dut (
    .clock(clock), .reset(reset), .bus(bus), .io_error(io_error), .io_done(io_done)
  );

  int total = 0, bad = 0;
  int tk = 0, wr_hi = 0, n_acc = 0, n_done = 0, pend = 0, lat = 2;
  int hold = 0, held = 0, hold_bad = 0, valid_tick = -1, done_tick = -1;
  bit inj = 0;
  logic [14:0] acc_addr = '0, hold_addr = '0;
  logic [15:0] sb[$];

  function automatic logic [15:0] mem_word(input logic [14:0] a);
    logic [7:0] lo;
    lo = a[7:0];
    return (a == 15'd3) ? 16'h1234 : {lo, ~lo};
  endfunction

  function automatic logic [15:0] sw(input logic [15:0] w);
    return {w[7:0], w[15:8]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one cycle: observe outputs at negedge, then drive the memory side for the next posedge
  task automatic tick();
    @(negedge clock);
    tk++;
    if (bus.io_ioctl_waitReq) wr_hi++;
    if (io_done) begin n_done++; done_tick = tk; end
    bus.io_mem_valid = 1'b0;
    if (inj) begin
      bus.io_mem_valid = 1'b1; bus.io_mem_dout = 16'hDEAD; inj = 0; valid_tick = tk;
    end
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        bus.io_mem_valid = 1'b1; bus.io_mem_dout = mem_word(acc_addr); valid_tick = tk;
      end
    end
    bus.io_mem_waitReq = 1'b0;
    if (bus.io_mem_rd) begin
      if (hold > 0) begin
        bus.io_mem_waitReq = 1'b1; hold--; held++;
        if (bus.io_mem_addr !== hold_addr) hold_bad++;
      end else begin
        n_acc++; acc_addr = bus.io_mem_addr;
        if (lat > 0) pend = lat;
      end
    end
  endtask

  task automatic do_read(input logic [26:0] a, input logic [7:0] idx, input logic [15:0] exp,
                         input bit dup, input string tag);
    int n;
    logic [15:0] e;
    sb.push_back(exp);
    wr_hi = 0; n_acc = 0;
    bus.io_ioctl_addr = a; bus.io_ioctl_index = idx; bus.io_ioctl_rd = 1'b1;
    tick();
    bus.io_ioctl_rd = 1'b0;
    if (dup) begin
      tick(); bus.io_ioctl_rd = 1'b1; tick(); bus.io_ioctl_rd = 1'b0;
    end
    n = 0;
    while (bus.io_ioctl_waitReq && n < 60) begin tick(); n++; end
    check({tag, "_bound"}, 32'(n < 60), 32'd1);
    e = sb.pop_front();
    check({tag, "_din"}, bus.io_ioctl_din, e);
  endtask

  task automatic toggle_upload(input string tag);
    n_done = 0;
    bus.io_ioctl_upload = 1'b0;
    repeat (3) tick();
    check({tag, "_done"}, n_done, 1);
    bus.io_ioctl_upload = 1'b1;
    repeat (2) tick();
    check({tag, "_errclr"}, io_error, 1'b0);
  endtask

  initial begin
    int n;
    logic [15:0] e;
    reset = 1'b1;
    bus.io_ioctl_upload = 1'b0; bus.io_ioctl_rd = 1'b0; bus.io_ioctl_index = 8'h00;
    bus.io_ioctl_addr = '0; bus.io_mem_waitReq = 1'b0; bus.io_mem_dout = '0; bus.io_mem_valid = 1'b0;
    repeat (3) tick();
    check("rst_din", bus.io_ioctl_din, 16'h0);
    check("rst_wait", bus.io_ioctl_waitReq, 1'b0);
    check("rst_memrd", bus.io_mem_rd, 1'b0);
    check("rst_addr", bus.io_mem_addr, 15'h0);
    check("rst_err", io_error, 1'b0);
    check("rst_done", io_done, 1'b0);
    reset = 1'b0;
    bus.io_ioctl_upload = 1'b1;
    repeat (2) tick();

    lat = 2;
    do_read(27'd6, 8'h02, 16'h3412, 0, "basic");
    check("basic_wait", wr_hi, 4);
    check("basic_acc", n_acc, 1);
    check("basic_addr", acc_addr, 15'd3);
    check("basic_err", io_error, 1'b0);

    do_read(27'd6, 8'h01, 16'h3412, 0, "badidx");
    check("badidx_wait", wr_hi, 0);
    check("badidx_acc", n_acc, 0);

    do_read(27'd128, 8'h02, 16'hFFFF, 0, "oob");
    check("oob_wait", wr_hi, 0);
    check("oob_acc", n_acc, 0);

    do_read(27'd126, 8'h02, sw(mem_word(15'd63)), 0, "last");
    check("last_addr", acc_addr, 15'd63);

    lat = 0; n_done = 0;
    do_read(27'd10, 8'h02, 16'hFFFF, 0, "tmo");
    check("tmo_wait", wr_hi, 9);
    check("tmo_err", io_error, 1'b1);
    tick(); tick(); inj = 1; tick(); repeat (3) tick();
    check("late_din", bus.io_ioctl_din, 16'hFFFF);
    check("late_done", n_done, 0);
    lat = 2;
    do_read(27'd6, 8'h02, 16'h3412, 0, "after");
    check("after_acc", n_acc, 1);
    check("after_err", io_error, 1'b1);
    toggle_upload("tog1");

    lat = 4;
    do_read(27'd14, 8'h02, sw(mem_word(15'd7)), 1, "busy");
    check("busy_err", io_error, 1'b1);
    check("busy_acc", n_acc, 1);
    toggle_upload("tog2");

    lat = 1; hold = 5; held = 0; hold_bad = 0; hold_addr = 15'd10;
    do_read(27'd20, 8'h02, sw(mem_word(15'd10)), 0, "hold");
    check("hold_cyc", held, 5);
    check("hold_stable", hold_bad, 0);
    check("hold_acc", n_acc, 1);

    // upload drops while the memory read is in flight
    lat = 6; n_done = 0; valid_tick = -1; done_tick = -1;
    sb.push_back(sw(mem_word(15'd10)));
    bus.io_ioctl_addr = 27'd8; bus.io_ioctl_rd = 1'b1;
    tick();
    bus.io_ioctl_rd = 1'b0;
    tick(); tick();
    bus.io_ioctl_upload = 1'b0;
    tick();
    check("abort_wait", bus.io_ioctl_waitReq, 1'b0);
    n = 0;
    while (n_done == 0 && n < 30) begin tick(); n++; end
    check("abort_bound", 32'(n < 30), 32'd1);
    check("abort_done_t", done_tick, valid_tick + 1);
    repeat (3) tick();
    check("abort_done_n", n_done, 1);
    check("abort_err", io_error, 1'b0);
    e = sb.pop_front();
    check("abort_din", bus.io_ioctl_din, e);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/nvram_upload_responder.md
Name: nvram_upload_responder

Overview:
- Serves HPS upload (save) requests on the ioctl bus by reading 16-bit words from on-core NVRAM/EEPROM backing memory and returning them on io_ioctl_din.
- Sits between the hps_io ioctl upload signals and a memory read port using the waitReq/valid convention of the DDR interface.
- It is the responder counterpart to the download path: the HPS initiates, this block answers.

Parameters:
- INDEX, 8'h02, ioctl_index value this block responds to; other indices are ignored.
- ADDR_WIDTH, 16, byte-address width of the NVRAM window (word address = ADDR_WIDTH-1 bits).
- SIZE_BYTES, 128, valid window size in bytes, even; reads at or beyond it return 16'hFFFF.
- TIMEOUT, 255, maximum cycles to wait for io_mem_valid before substituting 16'hFFFF.

Ports:
- clock  in  1  single clock (clk_sys domain).
- reset  in  1  synchronous, active-high reset.
- io_ioctl_upload  in  1  HPS upload in progress.
- io_ioctl_rd  in  1  one-cycle read strobe from HPS.
- io_ioctl_index  in  8  selected file index.
- io_ioctl_addr  in  27  byte address; even, steps by 2.
- io_ioctl_din  out  16  read data returned to HPS, byte-swapped.
- io_ioctl_waitReq  out  1  high while a read is outstanding.
- io_mem_rd  out  1  memory read request.
- io_mem_addr  out  ADDR_WIDTH-1  word address.
- io_mem_waitReq  in  1  memory not ready to accept a request.
- io_mem_dout  in  16  memory read data.
- io_mem_valid  in  1  io_mem_dout valid this cycle.
- io_error  out  1  sticky: timeout or read strobe while busy; cleared by reset or a new upload start.
- io_done  out  1  one-cycle pulse when upload deasserts with no read outstanding.

Behaviour:
- Reset: state IDLE; io_ioctl_din=0, io_ioctl_waitReq=0, io_mem_rd=0, io_mem_addr=0, io_error=0, io_done=0; timeout counter 0.
- A request is accepted only if io_ioctl_upload=1, io_ioctl_index=INDEX and io_ioctl_rd=1. All other strobes are ignored.
- States:
  - IDLE: on an accepted request with addr<SIZE_BYTES, latch word address = addr[ADDR_WIDTH-1:1], assert waitReq the next cycle, go to REQ. On an accepted request with addr>=SIZE_BYTES, load din=16'hFFFF and hold waitReq=0 (zero-wait response); no memory access.
  - REQ: io_mem_rd=1 and io_mem_addr held until a cycle with io_mem_waitReq=0 (request accepted that cycle), then go to WAIT.
  - WAIT: count cycles. On io_mem_valid, din={dout[7:0],dout[15:8]}, waitReq=0 next cycle, go to IDLE. If the count reaches TIMEOUT, din=16'hFFFF, set io_error, waitReq=0, go to DRAIN.
  - DRAIN: waitReq=0; discard the late io_mem_valid, then IDLE. Also leave DRAIN after a further TIMEOUT cycles.
- io_mem_valid arriving in IDLE or REQ is ignored.
- Latency: with zero memory wait and valid N cycles after acceptance, waitReq is high for N+2 cycles.
- io_ioctl_rd while waitReq=1 or in DRAIN: ignored; io_error set.
- io_ioctl_upload falls mid-read:
  - In REQ: drop io_mem_rd and go to IDLE.
  - In WAIT: go to DRAIN.
  - io_ioctl_waitReq=0 within 1 cycle in both cases; io_done is not pulsed until the block returns to IDLE.
- io_done: pulses on a 1->0 edge of io_ioctl_upload seen in IDLE, or on the first cycle back in IDLE after an abort.
- Rising edge of io_ioctl_upload clears io_error.
- io_ioctl_din holds its last value between reads.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, REQ, WAIT, DRAIN);
  - the NVRAM ioctl index constant;
  - the FILL_WORD=16'hFFFF constant;
  - the byte-swap function, shared with the download path.
- Natural sub-module: upload_edge_detect (upload rise/fall detection, done pulse generation).
- Timeout counter stays inline.

Test Plan:
- Memory has 0x1234 at word 3, valid 2 cycles after accept. rd at addr 6, index 2 -> mem_rd with mem_addr=3; waitReq high 4 cycles; din=0x3412.
- rd at addr 128, SIZE_BYTES=128 -> din=0xFFFF, waitReq never asserts, mem_rd stays 0.
- rd with index 1 -> no mem_rd, waitReq 0, din unchanged.
- Memory never asserts valid, TIMEOUT=8 -> after 8 WAIT cycles din=0xFFFF and error=1; a valid arriving 3 cycles later is discarded; the next read returns correct data.
- mem_waitReq held high 5 cycles -> mem_rd and mem_addr stable all 5 cycles; exactly one accepted request.
- Upload drops while in WAIT -> waitReq=0 within 1 cycle; done pulses one cycle after the late valid is drained; error stays 0.
